// File: rtl/key_press_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : key_press_gen_if
// Description : Command/status bundle for the key-press generator.
//               master = command side (drives start/num, observes status)
//               slave  = generator side (key_press_gen)
//   start        : request, sampled only while the generator is idle
//   num[2:0]     : number of presses, latched on an accepted start
//   key_out      : emulated key, active low, idle high
//   busy         : sequence in progress
//   done         : one-cycle completion pulse
//   presses_sent : completed presses in the current or last sequence
// Revision    : 1.0 - initial release
// ============================================================================
interface key_press_gen_if;
  logic       start;
  logic [2:0] num;
  logic       key_out;
  logic       busy;
  logic       done;
  logic [2:0] presses_sent;

  modport master (
    output start,
    output num,
    input  key_out,
    input  busy,
    input  done,
    input  presses_sent
  );

  modport slave (
    input  start,
    input  num,
    output key_out,
    output busy,
    output done,
    output presses_sent
  );
endinterface
`default_nettype wire

// File: rtl/key_press_gen.sv
`default_nettype none
// ============================================================================
// Module      : key_press_gen
// Description : Emits a commanded number of active-low key presses on a
//               single key line, with fixed press and gap durations.
//               Optional contact-bounce emulation is enabled by defining the
//               macro KEY_BOUNCE_EN: each press/gap entry is then preceded by
//               a BOUNCE_CYCLES-long burst toggling every cycle.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous reset, active high
//               kp   - key_press_gen_if.slave (start, num, key_out, busy,
//                      done, presses_sent)
// Parameters  : PRESS_CYCLES  (1..2^24-1) low time per press
//               GAP_CYCLES    (1..2^24-1) high time after each press
//               BOUNCE_CYCLES (1..255)    bounce burst length
// Revision    : 1.0 - initial release
// ============================================================================
module key_press_gen #(
  parameter int unsigned PRESS_CYCLES  = 1000000,
  parameter int unsigned GAP_CYCLES    = 1000000,
  parameter int unsigned BOUNCE_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  key_press_gen_if.slave kp
);

  // Parameter ranges are what make the 24-bit counter saturation-free.
  generate
    if (PRESS_CYCLES < 1 || PRESS_CYCLES > 32'h00FF_FFFF) begin : g_press_range_err
      $error("key_press_gen: PRESS_CYCLES out of range 1..2^24-1");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 32'h00FF_FFFF) begin : g_gap_range_err
      $error("key_press_gen: GAP_CYCLES out of range 1..2^24-1");
    end
    if (BOUNCE_CYCLES < 1 || BOUNCE_CYCLES > 255) begin : g_bounce_range_err
      $error("key_press_gen: BOUNCE_CYCLES out of range 1..255");
    end
  endgenerate

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_PRESS = 2'd1;
  localparam logic [1:0] c_GAP   = 2'd2;
  localparam logic [1:0] c_FIN   = 2'd3;

  localparam logic [23:0] c_PRESS_LAST = 24'(PRESS_CYCLES - 1);
  localparam logic [23:0] c_GAP_LAST   = 24'(GAP_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [2:0]  rem_q, rem_d;
  logic        key_q, key_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  sent_q, sent_d;

`ifdef KEY_BOUNCE_EN
  localparam logic [23:0] c_BOUNCE_LAST = 24'(BOUNCE_CYCLES - 1);
  // High while the current PRESS/GAP is still in its bounce burst.
  logic bounce_q, bounce_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 24'd1;
    rem_d   = rem_q;
    key_d   = key_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sent_d  = sent_q;
`ifdef KEY_BOUNCE_EN
    bounce_d = bounce_q;
`endif

    case (state_q)
      c_IDLE: begin
        cnt_d = '0;
        if (kp.start) begin
          sent_d = '0;
          if (kp.num != 3'd0) begin
            rem_d   = kp.num;
            state_d = c_PRESS;
            key_d   = 1'b0;
            busy_d  = 1'b1;
`ifdef KEY_BOUNCE_EN
            bounce_d = 1'b1;
`endif
          end else begin
            // Zero presses: complete immediately without raising busy.
            state_d = c_FIN;
            done_d  = 1'b1;
          end
        end
      end

      c_PRESS: begin
`ifdef KEY_BOUNCE_EN
        if (bounce_q) begin
          key_d = ~key_q;
          if (cnt_q == c_BOUNCE_LAST) begin
            bounce_d = 1'b0;
            cnt_d    = '0;
            key_d    = 1'b0;
          end
        end else
`endif
        if (cnt_q == c_PRESS_LAST) begin
          state_d = c_GAP;
          cnt_d   = '0;
          key_d   = 1'b1;
          sent_d  = sent_q + 3'd1;
          rem_d   = rem_q - 3'd1;
`ifdef KEY_BOUNCE_EN
          bounce_d = 1'b1;
`endif
        end
      end

      c_GAP: begin
`ifdef KEY_BOUNCE_EN
        if (bounce_q) begin
          key_d = ~key_q;
          if (cnt_q == c_BOUNCE_LAST) begin
            bounce_d = 1'b0;
            cnt_d    = '0;
            key_d    = 1'b1;
          end
        end else
`endif
        if (cnt_q == c_GAP_LAST) begin
          cnt_d = '0;
          if (rem_q != 3'd0) begin
            state_d = c_PRESS;
            key_d   = 1'b0;
`ifdef KEY_BOUNCE_EN
            bounce_d = 1'b1;
`endif
          end else begin
            state_d = c_FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end

      c_FIN: begin
        // done_q is high for exactly this one cycle; start is not sampled.
        cnt_d   = '0;
        state_d = c_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      key_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sent_q  <= '0;
`ifdef KEY_BOUNCE_EN
      bounce_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sent_q  <= sent_d;
`ifdef KEY_BOUNCE_EN
      bounce_q <= bounce_d;
`endif
    end
  end

  assign kp.key_out      = key_q;
  assign kp.busy         = busy_q;
  assign kp.done         = done_q;
  assign kp.presses_sent = sent_q;

endmodule
`default_nettype wire

// File: tb/tb_key_press_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_press_gen
// Description : Directed self-checking bench for key_press_gen with
//               PRESS_CYCLES=4, GAP_CYCLES=3, BOUNCE_CYCLES=4. Honours the
//               KEY_BOUNCE_EN macro (adds the bounce waveform checks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_press_gen;

  localparam int P = 4;
  localparam int G = 3;
`ifdef KEY_BOUNCE_EN
  localparam int B = 4;
`else
  localparam int B = 0;
`endif
  localparam int PER = 2 * B + P + G;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  key_press_gen_if kp ();

  key_press_gen #(
    .PRESS_CYCLES (P),
    .GAP_CYCLES   (G),
    .BOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected key level in cycle T+i (i >= 1) of an n-press sequence.
  function automatic int exp_key(input int n, input int i);
    int m;
    if (n == 0 || i > n * PER) return 1;
    m = (i - 1) % PER;
    if (m < B)             return m % 2;
    if (m < B + P)         return 0;
    if (m < 2 * B + P)     return ((m - B - P) % 2 == 0) ? 1 : 0;
    return 1;
  endfunction

  // Completed presses: press k counts from its first GAP cycle.
  function automatic int exp_sent(input int n, input int i);
    int s;
    s = 0;
    for (int k = 0; k < n; k++)
      if (i >= k * PER + B + P + 1) s++;
    return s;
  endfunction

  // Issue a start with num=n, then check every cycle through one past done.
  // inject: re-assert start and change num to 7 while busy.
  task automatic run_seq(input int n, input bit inject, input string name);
    int last;
    int dones;
    last  = (n == 0) ? 1 : n * PER + 1;
    dones = 0;
    kp.num   = n[2:0];
    kp.start = 1'b1;
    step();
    kp.start = 1'b0;
    for (int i = 1; i <= last + 1; i++) begin
      if (inject && i == 5) begin
        kp.start = 1'b1;
        kp.num   = 3'd7;
      end
      if (inject && i == 11) kp.start = 1'b0;
      check($sformatf("%s key c%0d", name, i), 32'(kp.key_out), 32'(exp_key(n, i)));
      check($sformatf("%s busy c%0d", name, i), 32'(kp.busy),
            (n != 0 && i < last) ? 32'd1 : 32'd0);
      check($sformatf("%s done c%0d", name, i), 32'(kp.done), (i == last) ? 32'd1 : 32'd0);
      check($sformatf("%s sent c%0d", name, i), 32'(kp.presses_sent), 32'(exp_sent(n, i)));
      if (kp.done) dones++;
      step();
    end
    check($sformatf("%s done count", name), 32'(dones), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    kp.start = 1'b0;
    kp.num   = 3'd0;
    repeat (3) step();

    // Reset state.
    check("rst key",  32'(kp.key_out),      32'd1);
    check("rst busy", 32'(kp.busy),         32'd0);
    check("rst done", 32'(kp.done),         32'd0);
    check("rst sent", 32'(kp.presses_sent), 32'd0);
    rst = 1'b0;
    step();

    // Basic sequence, num=3.
    run_seq(3, 1'b0, "basic");
    step();

    // Zero presses: presses_sent must clear from the previous 3.
    run_seq(0, 1'b0, "zero");
    step();

    // start/num disturbed while busy.
    run_seq(3, 1'b1, "ignore");
    kp.num = 3'd0;
    step();

    // Reset during the second press of a num=5 sequence.
    kp.num   = 3'd5;
    kp.start = 1'b1;
    step();
    kp.start = 1'b0;
    for (int i = 1; i <= PER + B + 1; i++) begin
      check($sformatf("mid key c%0d", i),  32'(kp.key_out),      32'(exp_key(5, i)));
      check($sformatf("mid sent c%0d", i), 32'(kp.presses_sent), 32'(exp_sent(5, i)));
      step();
    end
    check("mid key low before rst", 32'(kp.key_out), 32'd0);
    rst = 1'b1;
    step();
    check("mid rst key",  32'(kp.key_out),      32'd1);
    check("mid rst busy", 32'(kp.busy),         32'd0);
    check("mid rst done", 32'(kp.done),         32'd0);
    check("mid rst sent", 32'(kp.presses_sent), 32'd0);
    rst = 1'b0;
    step();
    check("mid idle key", 32'(kp.key_out), 32'd1);
    run_seq(2, 1'b0, "after rst");
    step();

`ifdef KEY_BOUNCE_EN
    // Hand-written bounce waveform for num=1, B=4, P=4, G=3.
    begin
      int exp_b [15];
      exp_b = '{0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 1};
      kp.num   = 3'd1;
      kp.start = 1'b1;
      step();
      kp.start = 1'b0;
      for (int i = 1; i <= 16; i++) begin
        if (i <= 15)
          check($sformatf("bounce key c%0d", i), 32'(kp.key_out), 32'(exp_b[i-1]));
        check($sformatf("bounce done c%0d", i), 32'(kp.done), (i == 16) ? 32'd1 : 32'd0);
        step();
      end
    end
`else
    // Hand-written clean waveform for num=1, P=4, G=3: done at T+8.
    begin
      int exp_c [7];
      exp_c = '{0, 0, 0, 0, 1, 1, 1};
      kp.num   = 3'd1;
      kp.start = 1'b1;
      step();
      kp.start = 1'b0;
      for (int i = 1; i <= 8; i++) begin
        if (i <= 7)
          check($sformatf("clean key c%0d", i), 32'(kp.key_out), 32'(exp_c[i-1]));
        check($sformatf("clean done c%0d", i), 32'(kp.done), (i == 8) ? 32'd1 : 32'd0);
        step();
      end
    end
`endif
    check("final sent", 32'(kp.presses_sent), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
